ddc_complex_decimator: RTL and testbench
========================================

# ddc_complex_decimator

Parametrised successor to the fixed 32-bit downconverter.
- Mixes a real or complex ADC stream with an external NCO using a true complex multiply (e^-jωt).
- Decimates by a runtime power of two using an integrate-and-dump stage, then rounds and saturates to a configurable output width.
- Buffers results in a first-word-fall-through FIFO with valid/ready backpressure and a sticky overflow flag.
- Sits between the NCO/ADC front end and the packetiser.

## Interface
Parameters:
- IN_WIDTH, 16, signed ADC sample width per rail
- NCO_WIDTH, 16, signed NCO sine/cosine width (≥2)
- OUT_WIDTH, 16, signed output width per rail (≤ IN_WIDTH+NCO_WIDTH-1)
- DEC_MAX_LOG2, 8, maximum log2 decimation factor
- FIFO_DEPTH, 16, output FIFO entries (power of two, ≥2)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  processing clock
  - rst_n  in  1  synchronous active-low reset
- Configuration:
  - cfg_enable  in  1  0 flushes the datapath
  - cfg_complex_in  in  1  1 = use in_q; 0 = in_q treated as 0
  - cfg_dec_log2  in  $clog2(DEC_MAX_LOG2+1)  decimation D (factor 2^D)
- Input stream:
  - in_i, in_q  in  IN_WIDTH  signed input rails
  - in_valid  in  1  input sample strobe
  - nco_cos, nco_sin  in  NCO_WIDTH  signed NCO outputs, aligned with in_valid
- Output stream:
  - out_i, out_q  out  OUT_WIDTH  FIFO head
  - out_valid  out  1  FIFO non-empty
  - out_ready  in  1  consumer accept
- Status:
  - fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
  - overflow  out  1  sticky drop flag
  - clear_overflow  in  1  clears overflow

## Operation
- Reset (rst_n=0 at an edge) clears everything: out_i, out_q, out_valid, fifo_level, overflow, accumulators, decimation counter and pipeline valids all go to 0.
- Stage E1: register in_i, in_q, nco_cos, nco_sin when in_valid & cfg_enable. If cfg_complex_in=0, register in_q as 0.
- Stage E2: compute and register, full precision (IN+NCO+1 bits):
  - I = x_i·cos + x_q·sin
  - Q = x_q·cos − x_i·sin
- Stage E3: integrate and dump.
  - Accumulator width is IN+NCO+1+DEC_MAX_LOG2 (cannot overflow).
  - Count valid samples. When count = 2^D−1:
    - result = acc + sample
    - acc ← 0, count ← 0
  - Otherwise acc ← acc + sample, count ← count + 1.
- Scaling on dump:
  - Shift S = D + NCO_WIDTH − 1 + IN_WIDTH − OUT_WIDTH.
  - y = (result + 2^(S−1)) >>> S (arithmetic shift).
  - Saturate y to [−2^(OUT−1), 2^(OUT−1)−1].
  - Register y with a dump-valid flag.
- D latch and clamp:
  - D is latched from cfg_dec_log2 only when count = 0; a mid-block change applies from the next block.
  - Values > DEC_MAX_LOG2 are clamped to DEC_MAX_LOG2.
- Stage E4: push the (I,Q) pair into the FIFO.
  - A push is accepted if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the pair is dropped and overflow ← 1.
- Pop occurs when out_valid & out_ready. out_i/out_q show the head combinationally from FIFO storage and hold when out_ready=0.
- overflow behaviour:
  - Sticky until clear_overflow=1.
  - If a drop and clear_overflow coincide, the set wins.
- cfg_enable=0:
  - E1–E3 valids, accumulator and counter clear on the next edge; in-flight samples are discarded.
  - The FIFO keeps its contents and continues to drain.
- fifo_level changes:
  - +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.

## Timing
- Latency with D=0, FIFO empty: in_valid sampled at edge k → out_valid=1 after edge k+4.
- With D>0, the output follows the 2^D-th valid sample by the same 4 edges.
- Throughput is one input per clock; in_valid gaps are allowed and only valid samples count.
- out_valid deasserts the edge after the last pop.
- A reset mid-block discards the partial accumulation and the FIFO contents.

## Test plan
- Real mode, D=0: x_i=1000, cos=16384, sin=0 → out_i=500, out_q=0, out_valid 4 cycles after in_valid.
- Complex mode, D=0: x_i=x_q=32767, cos=sin=32767 → out_i saturates to 32767, out_q=0.
- D=2: four constant samples (x_i=1000, cos=16384) → exactly one output, out_i=500. A cfg_dec_log2 change after sample 2 takes effect only on the following block.
- Backpressure: out_ready=0, D=0, 20 valid inputs, FIFO_DEPTH=16 → fifo_level=16, overflow=1, and 16 entries drain in order once out_ready=1. clear_overflow → overflow=0.
- Full FIFO, out_ready=1 with a simultaneous push → push accepted, level stays 16, overflow stays 0.
- cfg_enable=0 mid-block (D=3, after 5 samples) with FIFO holding 2 entries → no output from the partial block and the 2 entries still drain. rst_n=0 → all outputs 0 on the next edge.

Source files
------------

// File: rtl/ddc_complex_decimator.sv
// ddc_complex_decimator
//   Digital downconverter with a complex mixer and integrate-and-dump decimation.
//   The ADC stream (real or complex) is multiplied by e^-jwt from an external
//   NCO. Blocks of 2^D valid samples are summed, then rounded, shifted and
//   saturated to OUT_WIDTH. Results go into a first-word-fall-through FIFO.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_enable          0 flushes the mixer/decimator pipeline (FIFO keeps draining)
//   cfg_complex_in      1 = use in_q, 0 = treat in_q as zero
//   cfg_dec_log2        decimation exponent D, clamped to DEC_MAX_LOG2
//   in_i, in_q          signed ADC rails, qualified by in_valid
//   nco_cos, nco_sin    signed NCO outputs aligned with in_valid
//   out_i, out_q        FIFO head, out_valid = FIFO non-empty, out_ready = accept
//   fifo_level          FIFO occupancy
//   overflow            sticky flag set when a result is dropped (FIFO full)
//   clear_overflow      clears overflow (a drop in the same cycle wins)
module ddc_complex_decimator #(
  parameter int IN_WIDTH     = 16,
  parameter int NCO_WIDTH    = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int DEC_MAX_LOG2 = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_enable,
  input  logic                                 cfg_complex_in,
  input  logic [$clog2(DEC_MAX_LOG2+1)-1:0]    cfg_dec_log2,
  input  logic signed [IN_WIDTH-1:0]           in_i,
  input  logic signed [IN_WIDTH-1:0]           in_q,
  input  logic                                 in_valid,
  input  logic signed [NCO_WIDTH-1:0]          nco_cos,
  input  logic signed [NCO_WIDTH-1:0]          nco_sin,
  output logic signed [OUT_WIDTH-1:0]          out_i,
  output logic signed [OUT_WIDTH-1:0]          out_q,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
  output logic                                 overflow,
  input  logic                                 clear_overflow
);

  localparam int DW         = $clog2(DEC_MAX_LOG2+1);
  localparam int MW         = IN_WIDTH + NCO_WIDTH;
  localparam int PROD_W     = MW + 1;
  localparam int ACC_W      = PROD_W + DEC_MAX_LOG2;
  localparam int CNT_W      = (DEC_MAX_LOG2 > 0) ? DEC_MAX_LOG2 : 1;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int SHIFT_BASE = NCO_WIDTH - 1 + IN_WIDTH - OUT_WIDTH;

  localparam logic [DW-1:0]           D_MAX    = DW'(DEC_MAX_LOG2);
  localparam logic [AW:0]             LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [ACC_W:0]   ONE      = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0]   SAT_MAX  = {{(ACC_W+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SAT_MIN  = {{(ACC_W+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [DW-1:0] clamp_d(input logic [DW-1:0] d);
    return (d > D_MAX) ? D_MAX : d;
  endfunction

  // Round half up, arithmetic shift by D + SHIFT_BASE, saturate to OUT_WIDTH.
  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic signed [OUT_WIDTH-1:0] round_sat(
    input logic signed [ACC_W-1:0] v,
    input logic [DW-1:0]           d
  );
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] y;
    int s;
    s   = int'(d) + SHIFT_BASE;
    ext = (ACC_W+1)'(v);
    rnd = (s > 0) ? (ONE <<< (s - 1)) : '0;
    y   = (ext + rnd) >>> s;
    if (y > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
    else if (y < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    else                  return y[OUT_WIDTH-1:0];
  endfunction

  // ---- E1: input capture ------------------------------------------------
  logic                        vld_p0;
  logic signed [IN_WIDTH-1:0]  xi_p0, xq_p0;
  logic signed [NCO_WIDTH-1:0] cos_p0, sin_p0;
  logic [DW-1:0]               d_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= in_valid & cfg_enable;
    if (in_valid & cfg_enable) begin
      xi_p0  <= in_i;
      xq_p0  <= cfg_complex_in ? in_q : '0;
      cos_p0 <= nco_cos;
      sin_p0 <= nco_sin;
      d_p0   <= clamp_d(cfg_dec_log2);
    end
  end

  // ---- E2: complex multiply by e^-jwt, full precision -------------------
  logic signed [MW-1:0]     p_ic, p_qs, p_qc, p_is;
  logic                     vld_p1;
  logic signed [PROD_W-1:0] i_p1, q_p1;
  logic [DW-1:0]            d_p1;

  assign p_ic = MW'(xi_p0) * MW'(cos_p0);
  assign p_qs = MW'(xq_p0) * MW'(sin_p0);
  assign p_qc = MW'(xq_p0) * MW'(cos_p0);
  assign p_is = MW'(xi_p0) * MW'(sin_p0);

  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0 & cfg_enable;
    if (vld_p0) begin
      i_p1 <= PROD_W'(p_ic) + PROD_W'(p_qs);
      q_p1 <= PROD_W'(p_qc) - PROD_W'(p_is);
      d_p1 <= d_p0;
    end
  end

  // ---- E3: integrate and dump ------------------------------------------
  // D travels with each sample; the block takes the D of its first sample,
  // so a configuration change mid-block applies from the next block.
  logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
  logic [CNT_W-1:0]        cnt, last_cnt;
  logic [DW-1:0]           d_lat, d_blk;
  logic                    vld_p2;
  logic signed [ACC_W-1:0] res_i_p2, res_q_p2;
  logic [DW-1:0]           d_res_p2;

  assign d_blk    = (cnt == '0) ? d_p1 : d_lat;
  assign last_cnt = ~({CNT_W{1'b1}} << d_blk);
  assign sum_i    = acc_i + ACC_W'(i_p1);
  assign sum_q    = acc_q + ACC_W'(q_p1);

  always_ff @(posedge clk) begin
    if (!rst_n || !cfg_enable) begin
      acc_i  <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      d_lat  <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (vld_p1) begin
        if (cnt == '0) d_lat <= d_p1;
        if (cnt == last_cnt) begin
          acc_i  <= '0;
          acc_q  <= '0;
          cnt    <= '0;
          vld_p2 <= 1'b1;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + 1'b1;
        end
      end
    end
    if (vld_p1 && cnt == last_cnt) begin
      res_i_p2 <= sum_i;
      res_q_p2 <= sum_q;
      d_res_p2 <= d_blk;
    end
  end

  // ---- E3 (scale): round, shift, saturate ---------------------------------
  logic                        vld_p3;
  logic signed [OUT_WIDTH-1:0] y_i_p3, y_q_p3;

  always_ff @(posedge clk) begin
    if (!rst_n || !cfg_enable) vld_p3 <= 1'b0;
    else                       vld_p3 <= vld_p2;
    if (vld_p2) begin
      y_i_p3 <= round_sat(res_i_p2, d_res_p2);
      y_q_p3 <= round_sat(res_q_p2, d_res_p2);
    end
  end

  // ---- E4: output FIFO --------------------------------------------------
  // A full FIFO still accepts a push when the head is popped in the same
  // cycle: the write lands in the slot being vacated.
  logic signed [OUT_WIDTH-1:0] mem_i [FIFO_DEPTH];
  logic signed [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        pop, push, drop, full;

  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == LVL_FULL);
  assign pop       = out_valid & out_ready;
  assign push      = vld_p3 & (~full | pop);
  assign drop      = vld_p3 & full & ~pop;
  assign out_i     = out_valid ? mem_i[rd_ptr] : '0;
  assign out_q     = out_valid ? mem_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr] <= y_i_p3;
      mem_q[wr_ptr] <= y_q_p3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddc_complex_decimator.sv
// Testbench for ddc_complex_decimator (default parameters).
module tb_ddc_complex_decimator;
  localparam int IW = 16;
  localparam int NW = 16;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_enable;
  logic                 cfg_complex_in;
  logic [3:0]           cfg_dec_log2;
  logic signed [IW-1:0] in_i, in_q;
  logic                 in_valid;
  logic signed [NW-1:0] nco_cos, nco_sin;
  logic signed [OW-1:0] out_i, out_q;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           fifo_level;
  logic                 overflow;
  logic                 clear_overflow;

  ddc_complex_decimator #(
    .IN_WIDTH(IW), .NCO_WIDTH(NW), .OUT_WIDTH(OW), .DEC_MAX_LOG2(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_complex_in(cfg_complex_in),
    .cfg_dec_log2(cfg_dec_log2), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
    .nco_cos(nco_cos), .nco_sin(nco_sin), .out_i(out_i), .out_q(out_q),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xi, xq, c, s;
    bit cplx;
    int ei, eq;
  } vec_t;

  typedef struct {
    int i, q;
  } pair_t;

  pair_t sb[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    n_out      = 0;

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: every accepted output is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got i=%0d q=%0d, expected no output", out_i, out_q);
      end else begin
        pair_t p;
        p = sb.pop_front();
        check("out_i", out_i, p.i);
        check("out_q", out_q, p.q);
      end
    end
  end

  // Reference: sum of 2^d identical mixed samples, round half up, shift, saturate.
  function automatic pair_t model(input longint xi, input longint xq, input longint c,
                                  input longint s, input bit cplx, input int d);
    longint vi, vq, yi, yq, half;
    int sh;
    pair_t r;
    if (!cplx) xq = 0;
    vi   = (xi * c + xq * s) * (64'sd1 <<< d);
    vq   = (xq * c - xi * s) * (64'sd1 <<< d);
    sh   = d + NW - 1 + IW - OW;
    half = 64'sd1 <<< (sh - 1);
    yi   = (vi + half) >>> sh;
    yq   = (vq + half) >>> sh;
    if (yi > 32767) yi = 32767;
    if (yi < -32768) yi = -32768;
    if (yq > 32767) yq = 32767;
    if (yq < -32768) yq = -32768;
    r.i = int'(yi);
    r.q = int'(yq);
    return r;
  endfunction

  task automatic send(input int xi, input int xq, input int c, input int s);
    in_i     = IW'(xi);
    in_q     = IW'(xq);
    nco_cos  = NW'(c);
    nco_sin  = NW'(s);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check("drain_pending", longint'(sb.size()) + longint'(out_valid), 0);
  endtask

  task automatic push_exp(input int i, input int q);
    pair_t p;
    p.i = i;
    p.q = q;
    sb.push_back(p);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];

  initial begin
    int n0;
    pair_t m;
    vecs[0] = '{1000, 0, 16384, 0, 1'b0, 500, 0};
    vecs[1] = '{32767, 32767, 32767, 32767, 1'b1, 32767, 0};
    vecs[2] = '{-1000, 0, 16384, 0, 1'b0, -500, 0};
    vecs[3] = '{1000, 0, 0, 16384, 1'b0, 0, -500};
    vecs[4] = '{0, 1000, 16384, 0, 1'b1, 0, 500};
    vecs[5] = '{0, 1000, 16384, 0, 1'b0, 0, 0};
    vecs[6] = '{-32768, -32768, 32767, 32767, 1'b1, -32768, 0};
    vecs[7] = '{1, 0, 16384, 0, 1'b0, 1, 0};
    vecs[8] = '{1, 0, 16383, 0, 1'b0, 0, 0};
    vecs[9] = '{1000, 2000, 16384, 8192, 1'b1, 1000, 750};

    rst_n = 1'b0; cfg_enable = 1'b1; cfg_complex_in = 1'b0; cfg_dec_log2 = 4'd0;
    in_i = '0; in_q = '0; in_valid = 1'b0; nco_cos = '0; nco_sin = '0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    idle(3);
    check("reset_out_valid", out_valid, 0);
    check("reset_fifo_level", fifo_level, 0);
    check("reset_overflow", overflow, 0);
    check("reset_out_i", out_i, 0);
    check("reset_out_q", out_q, 0);
    rst_n = 1'b1;
    idle(1);

    // Latency: sample at edge k, out_valid rises after edge k+4.
    send(1000, 0, 16384, 0);
    push_exp(500, 0);
    idle(3);
    check("latency_k3_out_valid", out_valid, 0);
    idle(1);
    check("latency_k4_out_valid", out_valid, 1);
    check("latency_fifo_level", fifo_level, 1);
    out_ready = 1'b1;
    wait_drain();

    // Table-driven D=0 vectors, back to back.
    n0 = n_out;
    for (int v = 0; v < 10; v++) begin
      cfg_complex_in = vecs[v].cplx;
      push_exp(vecs[v].ei, vecs[v].eq);
      send(vecs[v].xi, vecs[v].xq, vecs[v].c, vecs[v].s);
    end
    cfg_complex_in = 1'b0;
    wait_drain();
    check("table_output_count", n_out - n0, 10);

    // D=2 block with a gap, D changed to 1 after sample 2 -> applies next block.
    n0 = n_out;
    cfg_dec_log2 = 4'd2;
    push_exp(500, 0);
    send(1000, 0, 16384, 0);
    idle(1);
    send(1000, 0, 16384, 0);
    cfg_dec_log2 = 4'd1;
    send(1000, 0, 16384, 0);
    send(1000, 0, 16384, 0);
    push_exp(1000, 0);
    send(2000, 0, 16384, 0);
    send(2000, 0, 16384, 0);
    wait_drain();
    check("dec_block_count", n_out - n0, 2);

    // Out-of-range D clamps to DEC_MAX_LOG2 (256 samples per output).
    n0 = n_out;
    cfg_dec_log2 = 4'd15;
    m = model(1000, 0, 16384, 0, 1'b0, 8);
    push_exp(m.i, m.q);
    for (int k = 0; k < 256; k++) send(1000, 0, 16384, 0);
    cfg_dec_log2 = 4'd0;
    wait_drain();
    check("clamp_output_count", n_out - n0, 1);

    // Backpressure: 20 inputs into a 16-deep FIFO.
    out_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n < 16) begin
        m = model(100 * (n + 1), 0, 16384, 0, 1'b0, 0);
        push_exp(m.i, m.q);
      end
      send(100 * (n + 1), 0, 16384, 0);
    end
    idle(8);
    check("bp_fifo_level", fifo_level, 16);
    check("bp_overflow", overflow, 1);
    out_ready = 1'b1;
    wait_drain();
    check("bp_overflow_sticky", overflow, 1);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    check("bp_overflow_cleared", overflow, 0);

    // Full FIFO with a pop coinciding with a push.
    out_ready = 1'b0;
    cfg_complex_in = 1'b1;
    for (int n = 0; n < 16; n++) begin
      m = model(37 * n - 300, 11 * n, 20000, -7000, 1'b1, 0);
      push_exp(m.i, m.q);
      send(37 * n - 300, 11 * n, 20000, -7000);
    end
    idle(8);
    check("full_fifo_level", fifo_level, 16);
    m = model(-1234, 4321, -15000, 9000, 1'b1, 0);
    push_exp(m.i, m.q);
    send(-1234, 4321, -15000, 9000);
    idle(3);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("push_pop_full_level", fifo_level, 16);
    check("push_pop_full_overflow", overflow, 0);
    out_ready = 1'b1;
    wait_drain();
    cfg_complex_in = 1'b0;

    // cfg_enable=0 mid-block with two entries waiting in the FIFO.
    out_ready = 1'b0;
    push_exp(150, 0);
    send(300, 0, 16384, 0);
    push_exp(300, 0);
    send(600, 0, 16384, 0);
    idle(6);
    cfg_dec_log2 = 4'd3;
    for (int k = 0; k < 5; k++) send(1000, 0, 16384, 0);
    cfg_enable = 1'b0;
    idle(2);
    cfg_enable = 1'b1;
    idle(6);
    check("flush_fifo_level", fifo_level, 2);
    out_ready = 1'b1;
    wait_drain();
    push_exp(500, 0);
    for (int k = 0; k < 8; k++) send(1000, 0, 16384, 0);
    wait_drain();

    // Reset with a full FIFO, overflow set and a partial block accumulated.
    out_ready = 1'b0;
    cfg_dec_log2 = 4'd0;
    for (int k = 0; k < 17; k++) send(50, 0, 16384, 0);
    idle(8);
    check("pre_reset_overflow", overflow, 1);
    cfg_dec_log2 = 4'd1;
    send(1000, 0, 16384, 0);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    push_exp(1000, 0);
    send(2000, 0, 16384, 0);
    send(2000, 0, 16384, 0);
    out_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
